// File: rtl/sr_drv_pkg.sv
// Shared types and width helpers for the SR latch pulse driver.
// Imported by the top module and by the request debouncer.
package sr_drv_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE_S = 3'd1,
        DRIVE_R = 3'd2,
        GAP     = 3'd3,
        CHECK   = 3'd4
    } state_t;

    localparam int SYNC_STAGES = 2;

    // Counter that must hold the value d itself (saturating debounce count).
    function automatic int dbnc_width(input int d);
        int w;
        w = $clog2(d + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Down-counter shared by the DRIVE and GAP phases, loaded with N-1.
    function automatic int phase_cnt_width(input int p, input int g);
        int m;
        m = (p > g) ? p : g;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Request, latch-drive and status signals of the SR latch driver.
// The bench drives through master; the driver uses slave.
interface sr_latch_driver_if;

    logic set_req;
    logic clr_req;
    logic q_in;
    logic S;
    logic R;
    logic busy;
    logic expected_q;
    logic mismatch;

    modport master (
        output set_req,
        output clr_req,
        output q_in,
        input  S,
        input  R,
        input  busy,
        input  expected_q,
        input  mismatch
    );

    modport slave (
        input  set_req,
        input  clr_req,
        input  q_in,
        output S,
        output R,
        output busy,
        output expected_q,
        output mismatch
    );

endinterface

// File: rtl/sr_debounce.sv
// Synchroniser plus consecutive-sample debouncer for one raw push-button.
// Emits a one-cycle event on the rising edge of the debounced level.
module sr_debounce
    import sr_drv_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_event
);

    localparam int CW = dbnc_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level_d;
    logic                   w_sync;
    logic                   w_level;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_sync[gi] <= 1'b0;
                    end else begin
                        r_sync[gi] <= i_raw;
                    end
                end
            end else begin : g_chain
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_sync[gi] <= 1'b0;
                    end else begin
                        r_sync[gi] <= r_sync[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_level = (r_cnt == CNT_FULL);

    // The count saturates so the level holds for as long as the input stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= w_level;
            if (!w_sync) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_FULL) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_event = w_level & ~r_level_d;

endmodule

// File: rtl/sr_latch_driver.sv
// Turns debounced set/clear requests into exclusive, fixed-width S/R pulses
// for a downstream SR latch and verifies the latch Q after each command.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 3,
    parameter int GAP_CYCLES      = 2
) (
    input logic         clk,
    input logic         rst_n,
    sr_latch_driver_if.slave bus
);

    localparam int CW = phase_cnt_width(PULSE_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("sr_latch_driver: DEBOUNCE_CYCLES must be >= 1");
        end
        if (PULSE_CYCLES < 1) begin : g_bad_pulse
            $error("sr_latch_driver: PULSE_CYCLES must be >= 1");
        end
        if (GAP_CYCLES < 2) begin : g_bad_gap
            $error("sr_latch_driver: GAP_CYCLES must be >= 2");
        end
    endgenerate

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_next;
    logic                   w_take_set;
    logic                   w_take_clr;
    logic                   w_set_evt;
    logic                   w_clr_evt;
    logic                   r_pend_set;
    logic                   r_pend_clr;
    logic                   r_s;
    logic                   r_r;
    logic                   r_expected_q;
    logic                   r_mismatch;
    logic                   w_s_next;
    logic                   w_r_next;
    logic                   w_check_fail;
    logic [SYNC_STAGES-1:0] r_q_sync;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_set (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (bus.set_req),
        .o_event (w_set_evt)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (bus.clr_req),
        .o_event (w_clr_evt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_q_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_q_sync[gi] <= 1'b0;
                    end else begin
                        r_q_sync[gi] <= bus.q_in;
                    end
                end
            end else begin : g_chain
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_q_sync[gi] <= 1'b0;
                    end else begin
                        r_q_sync[gi] <= r_q_sync[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Live events are considered alongside pending flags so a fresh request
    // launches its pulse on the very next edge.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_take_set   = 1'b0;
        w_take_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend_clr || w_clr_evt) begin
                    w_state_next = DRIVE_R;
                    w_cnt_next   = PULSE_LOAD;
                    w_take_clr   = 1'b1;
                end else if (r_pend_set || w_set_evt) begin
                    w_state_next = DRIVE_S;
                    w_cnt_next   = PULSE_LOAD;
                    w_take_set   = 1'b1;
                end
            end
            DRIVE_S, DRIVE_R: begin
                if (r_cnt == '0) begin
                    w_state_next = GAP;
                    w_cnt_next   = GAP_LOAD;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    w_state_next = CHECK;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            CHECK: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_s_next     = (w_state_next == DRIVE_S);
        w_r_next     = (w_state_next == DRIVE_R);
        w_check_fail = (r_state == CHECK) && (r_q_sync[SYNC_STAGES-1] != r_expected_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s          <= 1'b0;
            r_r          <= 1'b0;
            r_pend_set   <= 1'b0;
            r_pend_clr   <= 1'b0;
            r_expected_q <= 1'b0;
            r_mismatch   <= 1'b0;
        end else begin
            r_s <= w_s_next;
            r_r <= w_r_next;
            if (w_take_clr) begin
                // Clear wins: any set request alongside it is discarded.
                r_pend_set   <= 1'b0;
                r_pend_clr   <= 1'b0;
                r_expected_q <= 1'b0;
            end else if (w_take_set) begin
                r_pend_set   <= 1'b0;
                r_pend_clr   <= r_pend_clr | w_clr_evt;
                r_expected_q <= 1'b1;
            end else begin
                r_pend_set <= r_pend_set | w_set_evt;
                r_pend_clr <= r_pend_clr | w_clr_evt;
            end
            if (w_check_fail) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    assign bus.S          = r_s;
    assign bus.R          = r_r;
    assign bus.busy       = (r_state != IDLE);
    assign bus.expected_q = r_expected_q;
    assign bus.mismatch   = r_mismatch;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: a latch model closes the Q loop and a
// command-occupancy reference model predicts every output each cycle.
module tb_sr_latch_driver;

    localparam int D = 4;
    localparam int P = 3;
    localparam int G = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic latch_q = 1'b0;
    logic force_q0 = 1'b0;

    int total = 0;
    int bad = 0;

    sr_latch_driver_if bus();

    sr_latch_driver #(
        .DEBOUNCE_CYCLES (D),
        .PULSE_CYCLES    (P),
        .GAP_CYCLES      (G)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge bus.S or posedge bus.R) begin
        latch_q <= bus.S ? 1'b1 : 1'b0;
    end

    assign bus.q_in = force_q0 ? 1'b0 : latch_q;

    // Reference model: a command is a block of P+G+1 busy cycles counted by m_rem.
    int m_run_s, m_run_c, m_rem;
    bit m_ss1, m_ss2, m_cs1, m_cs2, m_q1, m_q2;
    bit m_lvl_s, m_lvl_c, m_ps, m_pc, m_cmd_set, m_exp, m_mm;

    task automatic model_reset();
        m_run_s = 0; m_run_c = 0; m_rem = 0;
        m_ss1 = 0; m_ss2 = 0; m_cs1 = 0; m_cs2 = 0; m_q1 = 0; m_q2 = 0;
        m_lvl_s = 0; m_lvl_c = 0; m_ps = 0; m_pc = 0;
        m_cmd_set = 0; m_exp = 0; m_mm = 0;
    endtask

    task automatic model_step(input bit a_s, input bit a_c, input bit a_q);
        bit ls, lc, es, ec;
        int rem_old;
        ls = (m_run_s >= D);
        lc = (m_run_c >= D);
        es = ls && !m_lvl_s;
        ec = lc && !m_lvl_c;
        rem_old = m_rem;
        if (rem_old == 1 && m_q2 != m_exp) m_mm = 1;
        if (rem_old == 0 && (m_pc || ec)) begin
            m_rem = P + G + 1; m_cmd_set = 0; m_exp = 0; m_pc = 0; m_ps = 0;
        end else if (rem_old == 0 && (m_ps || es)) begin
            m_rem = P + G + 1; m_cmd_set = 1; m_exp = 1; m_ps = 0;
        end else begin
            if (m_rem > 0) m_rem = m_rem - 1;
            m_ps = m_ps || es;
            m_pc = m_pc || ec;
        end
        m_run_s = m_ss2 ? ((m_run_s < D) ? m_run_s + 1 : D) : 0;
        m_run_c = m_cs2 ? ((m_run_c < D) ? m_run_c + 1 : D) : 0;
        m_lvl_s = ls; m_lvl_c = lc;
        m_ss2 = m_ss1; m_ss1 = a_s;
        m_cs2 = m_cs1; m_cs1 = a_c;
        m_q2 = m_q1; m_q1 = a_q;
    endtask

    // {S, R, busy, expected_q, mismatch}
    function automatic logic [4:0] model_out();
        logic drive;
        drive = (m_rem > G + 1);
        return {m_cmd_set && drive, !m_cmd_set && drive, m_rem != 0, m_exp, m_mm};
    endfunction

    function automatic logic [4:0] dut_out();
        return {bus.S, bus.R, bus.busy, bus.expected_q, bus.mismatch};
    endfunction

    // Advance one clock; inputs are snapshotted on the falling edge.
    task automatic tick();
        bit a_s, a_c, a_q;
        @(negedge clk);
        a_s = bus.set_req; a_c = bus.clr_req; a_q = bus.q_in;
        @(posedge clk);
        if (rst_n) model_step(a_s, a_c, a_q);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        force_q0 = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            got = dut_out();
            total++;
            if (got !== 5'b0 || got !== model_out()) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, got, 5'b0);
            end
        end
        $display("test_reset: 20 idle cycles checked");
    endtask

    task automatic test_single_set();
        int s_cnt, b_cnt, first_s;
        logic [4:0] got;
        s_cnt = 0; b_cnt = 0; first_s = -1;
        bus.set_req = 1'b1;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (e == 9) bus.set_req = 1'b0;
            got = dut_out();
            total++;
            if (got !== model_out()) begin
                bad++;
                $display("FAIL single_set_model edge=%0d got=%b want=%b", e, got, model_out());
            end
            if (bus.S) begin s_cnt++; if (first_s < 0) first_s = e; end
            if (bus.R) begin
                total++; bad++;
                $display("FAIL single_set_r edge=%0d got R=1 want R=0", e);
            end
            if (bus.busy) b_cnt++;
        end
        total++;
        if (first_s !== 2 + D) begin bad++; $display("FAIL single_set_first_s got=%0d want=%0d", first_s, 2 + D); end
        total++;
        if (s_cnt !== P) begin bad++; $display("FAIL single_set_s_width got=%0d want=%0d", s_cnt, P); end
        total++;
        if (b_cnt !== P + G + 1) begin bad++; $display("FAIL single_set_busy got=%0d want=%0d", b_cnt, P + G + 1); end
        total++;
        if ({bus.expected_q, bus.mismatch} !== 2'b10) begin
            bad++; $display("FAIL single_set_status got=%b want=10", {bus.expected_q, bus.mismatch});
        end
        $display("test_single_set: first_s=%0d s_cycles=%0d busy_cycles=%0d", first_s, s_cnt, b_cnt);
    endtask

    task automatic test_glitch();
        int act;
        logic [4:0] got;
        act = 0;
        bus.set_req = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (e == 2) bus.set_req = 1'b0;
            got = dut_out();
            total++;
            if (got !== model_out()) begin
                bad++;
                $display("FAIL glitch_model edge=%0d got=%b want=%b", e, got, model_out());
            end
            if (bus.S || bus.R || bus.busy) act++;
        end
        total++;
        if (act !== 0) begin bad++; $display("FAIL glitch_activity got=%0d want=0", act); end
        $display("test_glitch: active_cycles=%0d", act);
    endtask

    task automatic test_simultaneous();
        int s_cnt, r_cnt;
        logic [4:0] got;
        s_cnt = 0; r_cnt = 0;
        bus.set_req = 1'b1;
        bus.clr_req = 1'b1;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (e == 9) begin bus.set_req = 1'b0; bus.clr_req = 1'b0; end
            got = dut_out();
            total++;
            if (got !== model_out()) begin
                bad++;
                $display("FAIL simul_model edge=%0d got=%b want=%b", e, got, model_out());
            end
            if (bus.S) s_cnt++;
            if (bus.R) r_cnt++;
        end
        total++;
        if ({s_cnt, r_cnt, bus.expected_q} !== {32'd0, P, 1'b0}) begin
            bad++;
            $display("FAIL simul_result got s=%0d r=%0d eq=%b want s=0 r=%0d eq=0", s_cnt, r_cnt, bus.expected_q, P);
        end
        $display("test_simultaneous: s_cycles=%0d r_cycles=%0d", s_cnt, r_cnt);
    endtask

    task automatic test_back_to_back();
        int s_last, r_first, r_cnt;
        logic [4:0] got;
        s_last = -1; r_first = -1; r_cnt = 0;
        bus.set_req = 1'b1;
        for (int e = 0; e < 35; e++) begin
            tick();
            if (e == 1) bus.clr_req = 1'b1;
            if (e == 11) begin bus.set_req = 1'b0; bus.clr_req = 1'b0; end
            got = dut_out();
            total++;
            if (got !== model_out()) begin
                bad++;
                $display("FAIL b2b_model edge=%0d got=%b want=%b", e, got, model_out());
            end
            if (bus.S) s_last = e;
            if (bus.R) begin r_cnt++; if (r_first < 0) r_first = e; end
        end
        total++;
        if (r_first - s_last !== G + 3) begin
            bad++; $display("FAIL b2b_spacing got=%0d want=%0d", r_first - s_last, G + 3);
        end
        total++;
        if (r_cnt !== P) begin bad++; $display("FAIL b2b_r_width got=%0d want=%0d", r_cnt, P); end
        $display("test_back_to_back: s_last=%0d r_first=%0d r_cycles=%0d", s_last, r_first, r_cnt);
    endtask

    task automatic test_mismatch();
        logic [4:0] got;
        do_reset();
        force_q0 = 1'b1;
        bus.set_req = 1'b1;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (e == 9) bus.set_req = 1'b0;
            if (e == 20) force_q0 = 1'b0;
            got = dut_out();
            total++;
            if (got !== model_out()) begin
                bad++;
                $display("FAIL mismatch_model edge=%0d got=%b want=%b", e, got, model_out());
            end
        end
        total++;
        if (bus.mismatch !== 1'b1) begin bad++; $display("FAIL mismatch_sticky got=%b want=1", bus.mismatch); end
        do_reset();
        tick();
        total++;
        if (bus.mismatch !== 1'b0) begin bad++; $display("FAIL mismatch_cleared got=%b want=0", bus.mismatch); end
        $display("test_mismatch: sticky flag checked and cleared by reset");
    endtask

    task automatic test_reset_mid_pulse();
        int seen_s, late;
        logic [4:0] got;
        seen_s = 0; late = 0;
        bus.set_req = 1'b1;
        for (int e = 0; e < 20 && seen_s == 0; e++) begin
            tick();
            if (e == 3) bus.clr_req = 1'b1;
            if (bus.S) seen_s = 1;
        end
        total++;
        if (seen_s !== 1) begin bad++; $display("FAIL midrst_no_s got=%0d want=1", seen_s); end
        #2;
        rst_n = 1'b0;
        #1;
        got = dut_out();
        total++;
        if (got !== 5'b0) begin bad++; $display("FAIL midrst_async got=%b want=00000", got); end
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 0; e < 25; e++) begin
            tick();
            got = dut_out();
            total++;
            if (got !== model_out()) begin
                bad++;
                $display("FAIL midrst_model edge=%0d got=%b want=%b", e, got, model_out());
            end
            if (bus.S || bus.R) late++;
        end
        total++;
        if (late !== 0) begin bad++; $display("FAIL midrst_late_pulse got=%0d want=0", late); end
        $display("test_reset_mid_pulse: post-release pulse cycles=%0d", late);
    endtask

    task automatic test_random();
        int hold_s, hold_c;
        logic [4:0] got;
        do_reset();
        hold_s = 0; hold_c = 0;
        for (int e = 0; e < 1500; e++) begin
            if (hold_s == 0) begin bus.set_req = 1'($urandom_range(0, 1)); hold_s = $urandom_range(1, 14); end
            if (hold_c == 0) begin bus.clr_req = 1'($urandom_range(0, 1)); hold_c = $urandom_range(1, 14); end
            if ($urandom_range(0, 199) == 0) force_q0 = ~force_q0;
            hold_s--; hold_c--;
            tick();
            got = dut_out();
            total++;
            if (got !== model_out() || (bus.S && bus.R)) begin
                bad++;
                $display("FAIL random_model cyc=%0d got=%b want=%b", e, got, model_out());
            end
        end
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        force_q0 = 1'b0;
        $display("test_random: 1500 cycles compared");
    endtask

    initial begin
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        model_reset();
        test_reset();
        test_single_set();
        test_glitch();
        test_simultaneous();
        test_back_to_back();
        test_mismatch();
        test_reset_mid_pulse();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Clocked front-end that generates clean, mutually exclusive S and R pulses for the gate-level SR latch, which sits directly downstream and is driven by this block's S/R outputs. Raw set/clear push-button requests are synchronised, debounced, arbitrated and converted into fixed-width pulses separated by a settling gap. The latch's Q output is fed back and checked against the expected state after every command.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised-high samples required to accept a request; legal range is ≥1.
- PULSE_CYCLES, 3: S or R pulse width in clk cycles; legal range is ≥1.
- GAP_CYCLES, 2: cycles with both S and R low after a pulse, before Q is checked; legal range is ≥2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, asynchronous assert, active-low
- set_req  input  1  raw, asynchronous set request (level)
- clr_req  input  1  raw, asynchronous clear request (level)
- q_in  input  1  latch Q feedback (asynchronous)
- S  output  1  latch set drive, registered
- R  output  1  latch reset drive, registered
- busy  output  1  high whenever state ≠ IDLE
- expected_q  output  1  latch value the last issued command should produce
- mismatch  output  1  sticky error: synchronised Q differed from expected_q at a CHECK

## Operation
- set_req, clr_req and q_in each pass through a 2-flop synchroniser.
- Debounce, per request:
  - A counter increments while the synchronised input is high and clears to 0 when it is low.
  - The debounced level asserts when the count reaches DEBOUNCE_CYCLES and holds while the input stays high.
  - Only the rising edge of the debounced level is an event.
- Each event sets a pending flag (pend_set, pend_clr).
  - Repeat events while a flag is already set collapse into that one flag.
  - Events arriving while busy are held pending.
- FSM states: IDLE, DRIVE_S, DRIVE_R, GAP, CHECK.
  - IDLE, pend_clr set: go to DRIVE_R; clear pend_clr **and** pend_set (clear wins; a simultaneous set is discarded); expected_q ← 0.
  - IDLE, only pend_set: go to DRIVE_S; clear pend_set; expected_q ← 1.
  - DRIVE_S / DRIVE_R: hold for PULSE_CYCLES cycles, then go to GAP.
  - GAP: hold for GAP_CYCLES cycles, then go to CHECK.
  - CHECK: one cycle; if synchronised Q ≠ expected_q, set mismatch; then go to IDLE.
- S is high only in DRIVE_S; R is high only in DRIVE_R. S and R are never high in the same cycle, which is invariant.
- mismatch is cleared only by rst_n.
- A single down-counter (width from PULSE/GAP maximum) serves both the DRIVE and GAP states.

## Timing
- Reset values: S=0, R=0, busy=0, expected_q=0, mismatch=0, FSM=IDLE, pending flags=0, debounce counters=0, synchroniser flops=0.
- Asserting rst_n mid-pulse drops S/R immediately; pending requests are lost.
- Edge 0 is the first clk edge that samples set_req high, with set_req held high afterwards:
  - Debounced set asserts at edge 1+DEBOUNCE_CYCLES.
  - S rises at edge 2+DEBOUNCE_CYCLES and is high for exactly PULSE_CYCLES cycles.
  - busy rises on the same edge as S.
- Command occupancy is PULSE_CYCLES+GAP_CYCLES+1 cycles. busy falls on the edge leaving CHECK.
- Back-to-back commands: a pending request is accepted on the first IDLE cycle, so busy goes low for exactly one cycle between commands.
- A glitch shorter than DEBOUNCE_CYCLES synchronised samples produces no event.
- GAP_CYCLES ≥ 2 guarantees the Q synchroniser reflects the post-pulse latch value at CHECK.

## Structure
- Package sr_drv_pkg holds:
  - typedef enum logic [2:0] state_t for IDLE, DRIVE_S, DRIVE_R, GAP, CHECK.
  - Counter-width localparam helpers.
- Sub-module sr_debounce (2-flop synchroniser, counter, rising-edge output) is instantiated once each for set_req and clr_req.
- q_in uses a plain 2-flop synchroniser inside the top module.
- Elaboration-time checks enforce the legal parameter ranges.

## Test plan
- Reset then idle: all outputs 0 for 20 cycles.
- set_req high for 10 cycles (defaults), latch model connected: S high at edges 6–8, R never high, busy for 6 cycles, expected_q=1, mismatch=0.
- set_req high for 3 cycles only: no S/R pulse, busy stays 0.
- set_req and clr_req rise on the same cycle: one R pulse only, expected_q=0, no S pulse afterwards.
- clr_req event while a set command is in DRIVE_S: S pulse completes, then after one idle cycle a 3-cycle R pulse follows.
- q_in forced to 0 during a set command: mismatch=1 after CHECK and stays 1 until rst_n.
- rst_n asserted mid-S-pulse: S=0 asynchronously; no further pulse after release.
